pc_unit: RTL and testbench

Parametrised program-counter unit for the multi-cycle RV32I/RV64I core. It holds the architectural PC and the PC of the instruction in flight, and evaluates branch conditions with correct signed/unsigned compares. It commits the next PC only on an explicit strobe from the control FSM and counts retired instructions. It sits between the control FSM, register file and ALU, and drives the instruction-memory read address.

---
 rtl/pc_pkg.sv | 17 +
 rtl/pc_unit_branch_cmp.sv | 26 ++
 rtl/pc_unit.sv | 125 ++++++++++++
 tb/tb_pc_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared opcode and branch funct3 definitions for the program-counter unit.
package pc_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_funct3_e;

endpackage

// File: rtl/pc_unit_branch_cmp.sv
// Combinational branch comparator: evaluates the funct3 condition on rs1v/rs2v.
module branch_cmp
    import pc_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rs1v,
    input  logic [XLEN-1:0] rs2v,
    input  logic [2:0]      funct3,
    output logic            cond
);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            BEQ:     cond = (rs1v == rs2v);
            BNE:     cond = (rs1v != rs2v);
            BLT:     cond = ($signed(rs1v) <  $signed(rs2v));
            BGE:     cond = ($signed(rs1v) >= $signed(rs2v));
            BLTU:    cond = (rs1v <  rs2v);
            BGEU:    cond = (rs1v >= rs2v);
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC / pc_old / pending-branch / instret registers.
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
    parameter int unsigned     CNT_W        = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   rs1v,
    input  logic [XLEN-1:0]   rs2v,
    input  logic              cond_eval,
    input  logic              jump_sel,
    input  logic              pc_commit,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus4,
    output logic [XLEN-1:0]   pc_old,
    output logic              taken,
    output logic [CNT_W-1:0]  instret,
    output logic              misalign_trap,
    output logic [XLEN-1:0]   bad_target
);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pc_old_q, pc_old_d;
    logic             taken_q, taken_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             cond, dec, teff, go;
    logic [XLEN-1:0]  target;

    branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
        .rs1v   (rs1v),
        .rs2v   (rs2v),
        .funct3 (funct3),
        .cond   (cond)
    );

    assign pc_plus4 = pc_q + XLEN'(4);

    always_comb begin
        dec  = (opcode == OP_BRANCH) ? cond : ((opcode == OP_JAL) || (opcode == OP_JALR));
        // A same-cycle eval overrides the stored decision
        teff   = cond_eval ? dec : taken_q;
        go     = teff | jump_sel;
        target = go ? alu_result : pc_plus4;
        if (opcode == OP_JALR) begin
            target[0] = 1'b0;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic            trap_q, trap_d;
    logic [XLEN-1:0] bad_q, bad_d;
    logic            misalign;

    always_comb begin
        misalign = go && (target[1:0] != 2'b00);
        trap_d   = pc_commit && misalign;
        bad_d    = trap_d ? target : bad_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trap_q <= 1'b0;
            bad_q  <= '0;
        end else begin
            trap_q <= trap_d;
            bad_q  <= bad_d;
        end
    end

    assign misalign_trap = trap_q;
    assign bad_target    = bad_q;
`else
    logic unused_trap_vector;
    assign unused_trap_vector = ^TRAP_VECTOR;
    assign misalign_trap      = 1'b0;
    assign bad_target         = '0;
`endif

    always_comb begin
        pc_d      = pc_q;
        pc_old_d  = pc_old_q;
        instret_d = instret_q;
        taken_d   = taken_q;
        if (pc_commit) begin
`ifdef PC_MISALIGN_TRAP_EN
            pc_d = misalign ? TRAP_VECTOR : target;
`else
            pc_d = target & {{(XLEN-2){1'b1}}, 2'b00};
`endif
            pc_old_d  = pc_q;
            instret_d = instret_q + CNT_W'(1);
            taken_d   = 1'b0;
        end else if (cond_eval) begin
            taken_d = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_VECTOR;
            pc_old_q  <= RESET_VECTOR;
            taken_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            pc_q      <= pc_d;
            pc_old_q  <= pc_old_d;
            taken_q   <= taken_d;
            instret_q <= instret_d;
        end
    end

    assign pc      = pc_q;
    assign pc_old  = pc_old_q;
    assign taken   = taken_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus random traffic vs a reference model.
module tb_pc_unit;

    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] ALU  = 7'b0110011;
`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, cond_eval = 1'b0, jump_sel = 1'b0, pc_commit = 1'b0;
    logic [31:0] alu_result = '0, rs1v = '0, rs2v = '0;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] pc, pc_plus4, pc_old, bad_target;
    logic        taken, misalign_trap;
    logic [63:0] instret;

    pc_unit u_dut (
        .clk(clk), .rst(rst), .alu_result(alu_result), .opcode(opcode), .funct3(funct3),
        .rs1v(rs1v), .rs2v(rs2v), .cond_eval(cond_eval), .jump_sel(jump_sel),
        .pc_commit(pc_commit), .pc(pc), .pc_plus4(pc_plus4), .pc_old(pc_old), .taken(taken),
        .instret(instret), .misalign_trap(misalign_trap), .bad_target(bad_target)
    );

    logic        rst64 = 1'b1, commit64 = 1'b0;
    logic [63:0] pc64, pc_plus4_64, pc_old64, bad64;
    logic        taken64, trap64;
    logic [3:0]  instret64;

    pc_unit #(.XLEN(64), .RESET_VECTOR(64'hFFFF_FFFF_FFFF_FFFC), .CNT_W(4)) u_dut64 (
        .clk(clk), .rst(rst64), .alu_result(64'h0), .opcode(ALU), .funct3(3'b000),
        .rs1v(64'h0), .rs2v(64'h0), .cond_eval(1'b0), .jump_sel(1'b0), .pc_commit(commit64),
        .pc(pc64), .pc_plus4(pc_plus4_64), .pc_old(pc_old64), .taken(taken64),
        .instret(instret64), .misalign_trap(trap64), .bad_target(bad64)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_pc_old, m_bad;
    logic [63:0] m_instret;
    bit          m_taken, m_trap;

    function automatic bit ref_dec(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (op == JAL || op == JALR) return 1'b1;
        if (op != BR) return 1'b0;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one cycle of inputs, advance the model, and land 1 time unit after the edge.
    task automatic step(input bit r, input bit ce, input bit pcc, input bit js,
                        input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] t);
        bit d, te, go;
        logic [31:0] tgt;
        rst = r; cond_eval = ce; pc_commit = pcc; jump_sel = js;
        opcode = op; funct3 = f3; rs1v = a; rs2v = b; alu_result = t;
        m_trap = 1'b0;
        if (r) begin
            m_pc = '0; m_pc_old = '0; m_bad = '0; m_instret = '0; m_taken = 1'b0;
        end else begin
            d  = ref_dec(op, f3, a, b);
            te = ce ? d : m_taken;
            if (pcc) begin
                go  = te | js;
                tgt = go ? t : m_pc + 32'd4;
                if (op == JALR) tgt = tgt & ~32'd1;
                m_pc_old = m_pc;
                if (TRAP_EN && go && (tgt % 4 != 0)) begin
                    m_pc = 32'h100; m_bad = tgt; m_trap = 1'b1;
                end else if (TRAP_EN) begin
                    m_pc = tgt;
                end else begin
                    m_pc = tgt - (tgt % 4);
                end
                m_instret = m_instret + 1;
                m_taken   = 1'b0;
            end else if (ce) begin
                m_taken = d;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, ALU, 3'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, ALU, 3'd0, 32'h0, 32'h0, 32'h0);
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", pc); end
        n_checks++; if (pc_old !== 32'h0) begin n_fail++; $display("FAIL reset_pc_old got %h exp 0", pc_old); end
        n_checks++; if (pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc_plus4 got %h exp 4", pc_plus4); end
        n_checks++; if (taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken got %b exp 0", taken); end
        n_checks++; if (instret !== 64'h0) begin n_fail++; $display("FAIL reset_instret got %0d exp 0", instret); end
        n_checks++; if (misalign_trap !== 1'b0 || bad_target !== 32'h0) begin
            n_fail++; $display("FAIL reset_trap got %b/%h exp 0/0", misalign_trap, bad_target); end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 1, 0, ALU, 3'd0, 32'h0, 32'h0, $urandom);
            n_checks++; if (pc !== 32'(4 * i)) begin
                n_fail++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc, 4 * i); end
        end
        n_checks++; if (pc_old !== 32'h8) begin n_fail++; $display("FAIL seq_pc_old got %h exp 8", pc_old); end
        n_checks++; if (instret !== 64'd3) begin n_fail++; $display("FAIL seq_instret got %0d exp 3", instret); end
    endtask

    task automatic test_signed_unsigned();
        step(0, 1, 0, 0, BR, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h40);
        n_checks++; if (taken !== 1'b1) begin n_fail++; $display("FAIL blt_taken got %b exp 1", taken); end
        step(0, 0, 1, 0, BR, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h40);
        n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL blt_pc got %h exp 40", pc); end
        n_checks++; if (taken !== 1'b0) begin n_fail++; $display("FAIL blt_taken_clr got %b exp 0", taken); end
        step(0, 1, 1, 0, BR, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h40);
        n_checks++; if (pc !== 32'h44) begin n_fail++; $display("FAIL bltu_pc got %h exp 44", pc); end
    endtask

    task automatic test_jump_align();
        step(0, 1, 1, 0, JALR, 3'd0, 32'h0, 32'h0, 32'h81);
        n_checks++; if (pc !== 32'h80) begin n_fail++; $display("FAIL jalr_pc got %h exp 80", pc); end
        n_checks++; if (pc_old !== 32'h44) begin n_fail++; $display("FAIL jalr_pc_old got %h exp 44", pc_old); end
        step(0, 1, 1, 0, JAL, 3'd0, 32'h0, 32'h0, 32'h202);
        if (TRAP_EN) begin
            n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL jal_trap_pc got %h exp 100", pc); end
            n_checks++; if (bad_target !== 32'h202) begin
                n_fail++; $display("FAIL jal_bad_target got %h exp 202", bad_target); end
            n_checks++; if (misalign_trap !== 1'b1) begin
                n_fail++; $display("FAIL jal_trap_pulse got %b exp 1", misalign_trap); end
            idle();
            n_checks++; if (misalign_trap !== 1'b0) begin
                n_fail++; $display("FAIL jal_trap_len got %b exp 0", misalign_trap); end
        end else begin
            n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL jal_pc got %h exp 200", pc); end
            n_checks++; if (misalign_trap !== 1'b0) begin
                n_fail++; $display("FAIL jal_no_trap got %b exp 0", misalign_trap); end
        end
    endtask

    task automatic test_pending();
        step(0, 1, 0, 0, BR, 3'b100, 32'hFFFF_FFFB, 32'h3, 32'h300);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, ALU, 3'd0, $urandom, $urandom, $urandom);
        n_checks++; if (taken !== 1'b1) begin n_fail++; $display("FAIL pend_taken got %b exp 1", taken); end
        step(0, 0, 1, 0, ALU, 3'd0, 32'h0, 32'h0, 32'h300);
        n_checks++; if (pc !== 32'h300) begin n_fail++; $display("FAIL pend_pc got %h exp 300", pc); end
        n_checks++; if (taken !== 1'b0) begin n_fail++; $display("FAIL pend_taken_clr got %b exp 0", taken); end
        step(0, 1, 1, 0, BR, 3'b100, 32'hFFFF_FFFB, 32'h3, 32'h400);
        n_checks++; if (pc !== 32'h400 || taken !== 1'b0) begin
            n_fail++; $display("FAIL same_cycle got pc %h taken %b exp 400/0", pc, taken); end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 1, 1, ALU, 3'd0, 32'h0, 32'h0, 32'h1C);
        n_checks++; if (pc !== 32'h1C) begin n_fail++; $display("FAIL rmid_setup got %h exp 1c", pc); end
        step(0, 1, 0, 0, BR, 3'b000, 32'h7, 32'h7, 32'h500);
        n_checks++; if (taken !== 1'b1) begin n_fail++; $display("FAIL rmid_taken got %b exp 1", taken); end
        step(1, 1, 1, 1, BR, 3'b000, 32'h7, 32'h7, 32'h500);
        n_checks++; if (pc !== 32'h0 || pc_old !== 32'h0 || taken !== 1'b0 || instret !== 64'h0
                        || misalign_trap !== 1'b0 || bad_target !== 32'h0) begin
            n_fail++; $display("FAIL rmid_reset got pc %h old %h tk %b ir %0d tr %b bad %h exp all 0",
                               pc, pc_old, taken, instret, misalign_trap, bad_target); end
        step(0, 0, 1, 0, ALU, 3'd0, 32'h0, 32'h0, 32'h500);
        n_checks++; if (pc !== 32'h4) begin n_fail++; $display("FAIL rmid_next got %h exp 4", pc); end
    endtask

    task automatic test_wrap64();
        rst = 1'b0; cond_eval = 1'b0; pc_commit = 1'b0; jump_sel = 1'b0;
        rst64 = 1'b1; commit64 = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (pc64 !== 64'hFFFF_FFFF_FFFF_FFFC || pc_plus4_64 !== 64'h0) begin
            n_fail++; $display("FAIL w64_reset got pc %h p4 %h exp fffffffffffffffc/0", pc64, pc_plus4_64); end
        rst64 = 1'b0; commit64 = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (pc64 !== 64'h0 || pc_old64 !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_fail++; $display("FAIL w64_pc_wrap got pc %h old %h exp 0/fffffffffffffffc", pc64, pc_old64); end
        for (int i = 0; i < 14; i++) begin @(posedge clk); #1; end
        n_checks++; if (instret64 !== 4'hF) begin n_fail++; $display("FAIL w64_ir_max got %0d exp 15", instret64); end
        @(posedge clk); #1;
        commit64 = 1'b0;
        n_checks++; if (instret64 !== 4'h0 || pc64 !== 64'd60) begin
            n_fail++; $display("FAIL w64_ir_wrap got ir %0d pc %h exp 0/3c", instret64, pc64); end
    endtask

    task automatic test_random();
        logic [6:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    op = BR;
                2:       op = ($urandom_range(0, 1) != 0) ? JAL : JALR;
                default: op = ALU;
            endcase
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            step($urandom_range(0, 39) == 0, $urandom_range(0, 1) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0, op, 3'($urandom), a, b, $urandom);
            n_checks++;
            if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || pc_old !== m_pc_old || taken !== m_taken
                || instret !== m_instret || misalign_trap !== m_trap || bad_target !== m_bad) begin
                n_fail++;
                $display("FAIL rand[%0d] got pc %h p4 %h old %h tk %b ir %0d tr %b bad %h exp %h %h %h %b %0d %b %h",
                         i, pc, pc_plus4, pc_old, taken, instret, misalign_trap, bad_target,
                         m_pc, m_pc + 32'd4, m_pc_old, m_taken, m_instret, m_trap, m_bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_signed_unsigned();
        test_jump_align();
        test_pending();
        test_reset_mid();
        test_wrap64();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
